// File: rtl/fitness_eval_pkg.sv
// rtl/fitness_eval_pkg.sv - shared states and width helpers for the fitness evaluator
package fitness_eval_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        COMPARE,
        DONE
    } state_e;

    // Wide enough to hold tests*outw, the score of a perfect candidate
    function automatic int fit_width(input int tests, input int outw);
        return $clog2(tests * outw + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fitness_evaluator_if.sv
// rtl/fitness_evaluator_if.sv - host and candidate signals of the fitness evaluator (first_fail under EVAL_ERRLOG_EN)
interface fitness_evaluator_if
    import fitness_eval_pkg::*;
#(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 2,
    parameter int TEST_COUNT = 8,
    parameter int POP        = 1
);
    localparam int FIT_W = fit_width(TEST_COUNT, OUT_W);
    localparam int AW    = idx_width(TEST_COUNT);

    logic                    vec_we;
    logic [AW-1:0]           vec_addr;
    logic [IN_W+OUT_W-1:0]   vec_data;
    logic                    start;
    logic [IN_W-1:0]         stim;
    logic [POP*OUT_W-1:0]    resp;
    logic                    busy;
    logic                    done;
    logic [POP*FIT_W-1:0]    fitness;
`ifdef EVAL_ERRLOG_EN
    localparam int FFW = $clog2(TEST_COUNT + 1);
    logic [POP*FFW-1:0]      first_fail;
`endif

`ifdef EVAL_ERRLOG_EN
    modport master (output vec_we, vec_addr, vec_data, start, resp,
                    input  stim, busy, done, fitness, first_fail);
    modport slave  (input  vec_we, vec_addr, vec_data, start, resp,
                    output stim, busy, done, fitness, first_fail);
`else
    modport master (output vec_we, vec_addr, vec_data, start, resp,
                    input  stim, busy, done, fitness);
    modport slave  (input  vec_we, vec_addr, vec_data, start, resp,
                    output stim, busy, done, fitness);
`endif

endinterface

// File: rtl/match_popcount.sv
// rtl/match_popcount.sv - counts bit positions where a candidate output equals the expected value
module match_popcount #(
    parameter int OUT_W = 2
) (
    input  logic [OUT_W-1:0]           resp,
    input  logic [OUT_W-1:0]           expected,
    output logic [$clog2(OUT_W+1)-1:0] count
);
    localparam int CW = $clog2(OUT_W + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < OUT_W; i++) begin
            count = count + CW'(resp[i] == expected[i]);
        end
    end

endmodule

// File: rtl/fitness_evaluator.sv
// rtl/fitness_evaluator.sv - scores POP candidate circuits against a loadable vector table (first_fail under EVAL_ERRLOG_EN)
module fitness_evaluator
    import fitness_eval_pkg::*;
#(
    parameter int IN_W       = 3,
    parameter int OUT_W      = 2,
    parameter int TEST_COUNT = 8,
    parameter int POP        = 1,
    parameter int SETTLE_CYC = 1,
    parameter int FIT_W      = fit_width(TEST_COUNT, OUT_W)
) (
    input  logic               clk,
    input  logic               rst,
    fitness_evaluator_if.slave bus
);
    localparam int AW = idx_width(TEST_COUNT);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int CW = $clog2(OUT_W + 1);
    localparam int VW = IN_W + OUT_W;

    state_e            state, state_next;
    logic [VW-1:0]     table_q [TEST_COUNT];
    logic [AW-1:0]     idx;
    logic [SW-1:0]     settle_cnt;
    logic [IN_W-1:0]   stim_q;
    logic [FIT_W-1:0]  fit_q [POP];
    logic [CW-1:0]     cnt [POP];
    logic [OUT_W-1:0]  expected;
    logic              idle_like;
    logic              accept_start;
    logic              last_vec;

    assign idle_like    = (state == IDLE) || (state == DONE);
    assign accept_start = bus.start && idle_like;
    assign last_vec     = (idx == AW'(TEST_COUNT - 1));
    assign expected     = table_q[idx][OUT_W-1:0];

    assign bus.stim = stim_q;
    assign bus.busy = (state == APPLY) || (state == SETTLE) || (state == COMPARE);
    assign bus.done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = APPLY;
            APPLY:   state_next = (SETTLE_CYC == 0) ? COMPARE : SETTLE;
            SETTLE:  if (settle_cnt == SW'(SETTLE_CYC - 1)) state_next = COMPARE;
            COMPARE: state_next = last_vec ? DONE : APPLY;
            DONE:    state_next = bus.start ? APPLY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Table has no reset so a reset between runs keeps the loaded vectors
    always_ff @(posedge clk) begin
        if (bus.vec_we && idle_like && (32'(bus.vec_addr) < TEST_COUNT)) begin
            table_q[bus.vec_addr] <= bus.vec_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            settle_cnt <= '0;
            stim_q     <= '0;
        end else begin
            case (state)
                APPLY: begin
                    stim_q     <= table_q[idx][VW-1:OUT_W];
                    settle_cnt <= '0;
                end
                SETTLE:  settle_cnt <= settle_cnt + SW'(1);
                COMPARE: if (!last_vec) idx <= idx + AW'(1);
                default: ;
            endcase
            if (accept_start) idx <= '0;
        end
    end

    for (genvar k = 0; k < POP; k++) begin : g_cand
        match_popcount #(.OUT_W(OUT_W)) u_match (
            .resp     (bus.resp[k*OUT_W +: OUT_W]),
            .expected (expected),
            .count    (cnt[k])
        );

        always_ff @(posedge clk) begin
            if (rst || accept_start) fit_q[k] <= '0;
            else if (state == COMPARE) fit_q[k] <= fit_q[k] + FIT_W'(cnt[k]);
        end

        assign bus.fitness[k*FIT_W +: FIT_W] = fit_q[k];

`ifdef EVAL_ERRLOG_EN
        localparam int FFW = $clog2(TEST_COUNT + 1);
        logic [FFW-1:0] ff_q;

        // Only the first mismatching vector is latched; TEST_COUNT means none yet
        always_ff @(posedge clk) begin
            if (rst || accept_start) begin
                ff_q <= FFW'(TEST_COUNT);
            end else if (state == COMPARE && cnt[k] != CW'(OUT_W)
                         && ff_q == FFW'(TEST_COUNT)) begin
                ff_q <= FFW'(idx);
            end
        end

        assign bus.first_fail[k*FFW +: FFW] = ff_q;
`endif
    end

endmodule

// File: tb/tb_fitness_evaluator.sv
// tb/tb_fitness_evaluator.sv - directed scoreboard bench for fitness_evaluator, three full-adder candidates
module tb_fitness_evaluator;
    import fitness_eval_pkg::*;

    localparam int IN_W  = 3;
    localparam int OUT_W = 2;
    localparam int TC    = 8;
    localparam int POP   = 3;
    localparam int SC    = 1;
    localparam int FIT_W = fit_width(TC, OUT_W);
    localparam int LAT   = TC * (SC + 2) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fitness_evaluator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TEST_COUNT(TC), .POP(POP)) bus ();

    fitness_evaluator #(
        .IN_W(IN_W), .OUT_W(OUT_W), .TEST_COUNT(TC), .POP(POP), .SETTLE_CYC(SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [IN_W+OUT_W-1:0] tb_table [TC];
    logic [POP*FIT_W-1:0]  exp_q [$];

    function automatic logic [1:0] full_add(input logic [2:0] s);
        return 2'(s[2]) + 2'(s[1]) + 2'(s[0]);
    endfunction

    // Candidate 0 correct, 1 stuck at zero, 2 sum bit inverted
    function automatic logic [1:0] cand(input int k, input logic [2:0] s);
        case (k)
            0:       return full_add(s);
            1:       return 2'b00;
            default: return full_add(s) ^ 2'b01;
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < POP; k++) bus.resp[k*OUT_W +: OUT_W] = cand(k, bus.stim);
    end

    function automatic logic [POP*FIT_W-1:0] model_fitness();
        logic [POP*FIT_W-1:0] f;
        logic [1:0] diff;
        f = '0;
        for (int k = 0; k < POP; k++) begin
            for (int v = 0; v < TC; v++) begin
                diff = ~(cand(k, tb_table[v][4:2]) ^ tb_table[v][1:0]);
                f[k*FIT_W +: FIT_W] = f[k*FIT_W +: FIT_W] + FIT_W'($countones(diff));
            end
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one evaluation; optional restart pulse, busy-time write, or mid-run reset
    task automatic do_run(input string tag, input int restart_at, input int we_at, input int rst_at);
        int n;
        logic [POP*FIT_W-1:0] exp_fit;
        exp_q.push_back(model_fitness());
        bus.start = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            bus.start  = (n == restart_at);
            bus.vec_we = (n == we_at);
            if (n == we_at) begin
                bus.vec_addr = '0;
                bus.vec_data = '1;
            end
            if (n == 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            if (n == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk({tag, "_rst_busy"}, 64'(bus.busy), 64'd0);
                chk({tag, "_rst_stim"}, 64'(bus.stim), 64'd0);
                chk({tag, "_rst_fit"}, 64'(bus.fitness), 64'd0);
                chk({tag, "_rst_done"}, 64'(bus.done), 64'd0);
                void'(exp_q.pop_front());
                return;
            end
        end while (!bus.done && n < 200);
        bus.vec_we = 1'b0;
        bus.start  = 1'b0;
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        exp_fit = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk({tag, "_fitness"}, 64'(bus.fitness), 64'(exp_fit));
        step();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_fit_hold"}, 64'(bus.fitness), 64'(exp_fit));
    endtask

    initial begin
        bus.vec_we   = 1'b0;
        bus.vec_addr = '0;
        bus.vec_data = '0;
        bus.start    = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_stim", 64'(bus.stim), 64'd0);
        chk("reset_fit", 64'(bus.fitness), 64'd0);
`ifdef EVAL_ERRLOG_EN
        chk("reset_first_fail", 64'(bus.first_fail), 64'({4'd8, 4'd8, 4'd8}));
`endif

        for (int v = 0; v < TC; v++) begin
            tb_table[v]  = {3'(v), full_add(3'(v))};
            bus.vec_we   = 1'b1;
            bus.vec_addr = 3'(v);
            bus.vec_data = tb_table[v];
            step();
        end
        bus.vec_we = 1'b0;
        chk("model_fit_16_8_8", 64'(model_fitness()), 64'({5'd8, 5'd8, 5'd16}));

        do_run("basic", -1, -1, -1);
`ifdef EVAL_ERRLOG_EN
        chk("first_fail", 64'(bus.first_fail), 64'({4'd0, 4'd1, 4'd8}));
`endif
        do_run("restart", 10, -1, -1);
        do_run("midrst", -1, -1, 12);
        do_run("after_rst", -1, -1, -1);
        do_run("we_busy", -1, 5, -1);
        do_run("rerun", -1, -1, -1);

        tb_table[0]  = {3'b000, 2'b11};
        bus.vec_we   = 1'b1;
        bus.vec_addr = '0;
        bus.vec_data = tb_table[0];
        do_run("we_start", -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
